otter_intr_ctrl: RTL and testbench

- Parametrised multi-channel interrupt controller that drives the OTTER_MCU INTR input, replacing the single tied-off interrupt line.
- Synchronises NUM_CH external request lines and latches them per channel as edge- or level-sensitive.
- Exposes pending/enable/mode/ID registers on the existing IOBUS (IOBUS_ADDR/IOBUS_OUT/IOBUS_WR).
- Read data is returned combinationally for muxing into IOBUS_IN.

---
 rtl/otter_intr_pkg.sv | 10 +
 rtl/otter_irq_sync.sv | 27 ++
 rtl/otter_intr_ctrl.sv | 97 +++++++++
 tb/tb_otter_intr_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/otter_intr_pkg.sv
// Shared constants for the OTTER interrupt controller register window.
package otter_intr_pkg;
  localparam logic [2:0]  OFS_PENDING = 3'd0;
  localparam logic [2:0]  OFS_ENABLE  = 3'd1;
  localparam logic [2:0]  OFS_MODE    = 3'd2;
  localparam logic [2:0]  OFS_ID      = 3'd3;
  localparam logic [2:0]  OFS_GEN     = 3'd4;
  localparam logic [31:0] ID_NONE     = 32'h0000_001F;
  localparam int          MAX_CH      = 32;
endpackage

// File: rtl/otter_irq_sync.sv
// Per-channel input synchroniser with one extra history flop for rise detect.
module otter_irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq,
  output logic sync,
  output logic rise
);
  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Shift the async line through the flop chain; prev trails the last stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], irq};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign sync = chain[SYNC_STAGES-1];
  assign rise = sync & ~prev;
endmodule

// File: rtl/otter_intr_ctrl.sv
// Multi-channel interrupt controller feeding OTTER_MCU INTR over the IOBUS.
module otter_intr_ctrl
  import otter_intr_pkg::*;
#(
  parameter int          NUM_CH      = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h1100_0100,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NUM_CH-1:0] IRQ_IN,
  input  logic [31:0]       IOBUS_ADDR,
  input  logic [31:0]       IOBUS_OUT,
  input  logic              IOBUS_WR,
  output logic [31:0]       RDATA,
  output logic              SEL,
  output logic              INTR
);
  logic [NUM_CH-1:0] sync, rise;
  logic [NUM_CH-1:0] pending, enable, mode, pend_nxt, w1c, pe;
  logic              gen;
  logic [2:0]        ofs;
  logic              wr;
  logic              id_valid;
  logic [4:0]        id_idx;
  logic [31:0]       id_val;
  logic              unused_bits;

  otter_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync [NUM_CH-1:0] (
    .clk   (CLK),
    .rst_n (RST_N),
    .irq   (IRQ_IN),
    .sync  (sync),
    .rise  (rise)
  );

  assign SEL = (IOBUS_ADDR[31:5] == BASE_ADDR[31:5]);
  assign ofs = IOBUS_ADDR[4:2];
  assign wr  = IOBUS_WR & SEL;
  assign w1c = (wr && ofs == OFS_PENDING) ? IOBUS_OUT[NUM_CH-1:0] : '0;
  assign pe  = pending & enable;

  // Byte lane bits and upper write data beyond NUM_CH carry no meaning here.
  assign unused_bits = ^{IOBUS_ADDR[1:0], IOBUS_OUT};

  // Next pending: level channels follow sync; edge channels latch rises, set beats clear.
  always_comb begin
    pend_nxt = '0;
    for (int i = 0; i < NUM_CH; i++)
      pend_nxt[i] = mode[i] ? (rise[i] | (pending[i] & ~w1c[i])) : sync[i];
  end

  // Register file, pending latch and registered interrupt output.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pending <= '0;
      enable  <= '0;
      mode    <= '0;
      gen     <= 1'b0;
      INTR    <= 1'b0;
    end else begin
      pending <= pend_nxt;
      if (wr && ofs == OFS_ENABLE) enable <= IOBUS_OUT[NUM_CH-1:0];
      if (wr && ofs == OFS_MODE)   mode   <= IOBUS_OUT[NUM_CH-1:0];
      if (wr && ofs == OFS_GEN)    gen    <= IOBUS_OUT[0];
      INTR <= gen & (|pe);
    end
  end

  // Lowest-numbered pending-and-enabled channel wins the ID.
  always_comb begin
    id_valid = 1'b0;
    id_idx   = 5'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pe[i]) begin
        id_valid = 1'b1;
        id_idx   = 5'(i);
      end
    end
    id_val = id_valid ? {1'b1, 26'b0, id_idx} : ID_NONE;
  end

  // Combinational read mux; outside the window or unmapped reads 0.
  always_comb begin
    RDATA = 32'h0;
    if (SEL) begin
      case (ofs)
        OFS_PENDING: RDATA = 32'(pending);
        OFS_ENABLE:  RDATA = 32'(enable);
        OFS_MODE:    RDATA = 32'(mode);
        OFS_ID:      RDATA = id_val;
        OFS_GEN:     RDATA = {31'b0, gen};
        default:     RDATA = 32'h0;
      endcase
    end
  end
endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Directed bench for otter_intr_ctrl: register readback tables plus timing sequences.
module tb_otter_intr_ctrl;
  localparam logic [31:0] BASE = 32'h1100_0100;
  localparam logic [31:0] A_PEND = BASE + 32'h00;
  localparam logic [31:0] A_EN   = BASE + 32'h04;
  localparam logic [31:0] A_MODE = BASE + 32'h08;
  localparam logic [31:0] A_ID   = BASE + 32'h0C;
  localparam logic [31:0] A_GEN  = BASE + 32'h10;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [7:0]  IRQ_IN;
  logic [31:0] IOBUS_ADDR, IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] RDATA;
  logic        SEL, INTR;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t rst_tbl [6];
  rd_vec_t dec_tbl [6];

  otter_intr_ctrl #(.NUM_CH(8), .BASE_ADDR(BASE), .SYNC_STAGES(2)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .IRQ_IN     (IRQ_IN),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .RDATA      (RDATA),
    .SEL        (SEL),
    .INTR       (INTR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    IOBUS_ADDR = a;
    IOBUS_OUT  = d;
    IOBUS_WR   = 1'b1;
    tick();
    IOBUS_WR   = 1'b0;
    IOBUS_OUT  = 32'h0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    IOBUS_ADDR = a;
    IOBUS_WR   = 1'b0;
    #1;
    chk(name, RDATA, exp);
  endtask

  task automatic run_tbl(input rd_vec_t t [6], input string tag);
    for (int i = 0; i < 6; i++) rd_chk({tag, ".", t[i].name}, t[i].addr, t[i].exp);
  endtask

  initial begin
    rst_tbl[0] = '{"pend", A_PEND, 32'h0};
    rst_tbl[1] = '{"en",   A_EN,   32'h0};
    rst_tbl[2] = '{"mode", A_MODE, 32'h0};
    rst_tbl[3] = '{"id",   A_ID,   32'h0000_001F};
    rst_tbl[4] = '{"gen",  A_GEN,  32'h0};
    rst_tbl[5] = '{"unm",  BASE + 32'h14, 32'h0};

    RST_N = 1'b0; IRQ_IN = '0; IOBUS_ADDR = '0; IOBUS_OUT = '0; IOBUS_WR = 1'b0;

    // 1. reset and readback
    ticks(3);
    RST_N = 1'b1;
    tick();
    run_tbl(rst_tbl, "rst");
    chk("rst.intr", {31'b0, INTR}, 32'h0);

    // 2. edge capture, latency, W1C
    wr(A_MODE, 32'hFF);
    wr(A_EN,   32'h08);
    wr(A_GEN,  32'h1);
    IRQ_IN[3] = 1'b1;
    ticks(3);
    rd_chk("e.pend3", A_PEND, 32'h08);
    chk("e.intr3", {31'b0, INTR}, 32'h0);
    tick();
    chk("e.intr4", {31'b0, INTR}, 32'h1);
    rd_chk("e.id", A_ID, 32'h8000_0003);
    IRQ_IN[3] = 1'b0;
    wr(A_PEND, 32'h08);
    rd_chk("e.pend_clr", A_PEND, 32'h0);
    chk("e.intr_w1", {31'b0, INTR}, 32'h1);
    tick();
    chk("e.intr_w2", {31'b0, INTR}, 32'h0);
    ticks(4);
    rd_chk("e.pend_fall", A_PEND, 32'h0);

    // 3. priority and mask
    wr(A_EN, 32'h24);
    IRQ_IN = 8'h24;
    ticks(3);
    IRQ_IN = 8'h00;
    ticks(3);
    rd_chk("p.id2", A_ID, 32'h8000_0002);
    chk("p.intr", {31'b0, INTR}, 32'h1);
    wr(A_PEND, 32'h04);
    rd_chk("p.id5", A_ID, 32'h8000_0005);
    wr(A_EN, 32'h00);
    rd_chk("p.id_none", A_ID, 32'h0000_001F);
    tick();
    chk("p.intr_off", {31'b0, INTR}, 32'h0);
    rd_chk("p.pend", A_PEND, 32'h20);
    wr(A_PEND, 32'hFF);
    rd_chk("p.pend_clr", A_PEND, 32'h0);

    // 4. level mode
    wr(A_MODE, 32'h00);
    wr(A_EN,   32'h01);
    IRQ_IN[0] = 1'b1;
    ticks(5);
    chk("l.intr", {31'b0, INTR}, 32'h1);
    wr(A_PEND, 32'h01);
    rd_chk("l.w1c_noeff", A_PEND, 32'h01);
    IRQ_IN[0] = 1'b0;
    ticks(2);
    rd_chk("l.pend2", A_PEND, 32'h01);
    tick();
    rd_chk("l.pend3", A_PEND, 32'h00);
    chk("l.intr3", {31'b0, INTR}, 32'h1);
    tick();
    chk("l.intr4", {31'b0, INTR}, 32'h0);

    // 5. set wins over W1C on the same edge
    wr(A_MODE, 32'hFF);
    ticks(2);
    IRQ_IN[1] = 1'b1;
    ticks(2);
    wr(A_PEND, 32'h02);
    rd_chk("c.set_wins", A_PEND, 32'h02);
    wr(A_PEND, 32'h02);
    rd_chk("c.clr_after", A_PEND, 32'h00);
    IRQ_IN[1] = 1'b0;
    ticks(3);

    // 6. decode: out-of-window and unmapped writes ignored
    IOBUS_ADDR = BASE + 32'h20;
    #1;
    chk("d.sel_out", {31'b0, SEL}, 32'h0);
    IOBUS_ADDR = BASE + 32'h13;
    #1;
    chk("d.sel_in", {31'b0, SEL}, 32'h1);
    wr(BASE + 32'h20, 32'hFFFF_FFFF);
    wr(BASE + 32'h14, 32'hFFFF_FFFF);
    dec_tbl[0] = '{"en",   A_EN,   32'h01};
    dec_tbl[1] = '{"mode", A_MODE, 32'hFF};
    dec_tbl[2] = '{"gen",  A_GEN,  32'h1};
    dec_tbl[3] = '{"pend", A_PEND, 32'h0};
    dec_tbl[4] = '{"out",  BASE + 32'h20, 32'h0};
    dec_tbl[5] = '{"unm",  BASE + 32'h14, 32'h0};
    run_tbl(dec_tbl, "dec");
    rd_chk("d.alias", BASE + 32'h06, 32'h01);

    // 6b. reset mid-operation with a write in flight
    IRQ_IN = 8'hFF;
    ticks(4);
    rd_chk("r.pend_ff", A_PEND, 32'hFF);
    RST_N = 1'b0;
    wr(A_EN, 32'hFF);
    run_tbl(rst_tbl, "rmid");
    chk("rmid.intr", {31'b0, INTR}, 32'h0);
    IRQ_IN = 8'h00;
    RST_N  = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
